// File: rtl/btn_debounce.sv
// Four-channel push-button synchroniser, debouncer and press-edge detector.
// Optional long-press detection is enabled by defining BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter bit BTN_ACTIVE_LOW    = 1'b1,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic       btn_0,
  output logic       btn_1,
  output logic       btn_2,
  output logic       btn_3,
  output logic [3:0] btn_press
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  ,
  output logic [3:0] btn_long
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r [4];
  logic [CW-1:0]          cnt_r  [4];
  logic [3:0]             q_r;
  logic [3:0]             q_d_r;
  logic [3:0]             s;

  // Normalise pad polarity so that 1 always means pressed.
  assign s = btn_raw ^ {4{BTN_ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sync_r[i] <= '0;
        cnt_r[i]  <= '0;
      end
      q_r       <= '0;
      q_d_r     <= '0;
      btn_press <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], s[i]};
        // Any cycle of agreement restarts the count, so short glitches never land.
        if (sync_r[i][SYNC_STAGES-1] == q_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          q_r[i]   <= sync_r[i][SYNC_STAGES-1];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
      q_d_r     <= q_r;
      btn_press <= q_r & ~q_d_r;
    end
  end

  assign btn_0 = q_r[0];
  assign btn_1 = q_r[1];
  assign btn_2 = q_r[2];
  assign btn_3 = q_r[3];

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_PRESS_CYCLES);

  logic [LW-1:0] hold_r [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hold_r[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!q_r[i])
          hold_r[i] <= '0;
        else if (hold_r[i] != LONG_MAX)
          hold_r[i] <= hold_r[i] + LW'(1);
      end
    end
  end

  // Gated by q so the long flag drops on the very edge the level falls.
  always_comb begin
    btn_long = '0;
    for (int i = 0; i < 4; i++) btn_long[i] = q_r[i] & (hold_r[i] == LONG_MAX);
  end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised and directed bench for btn_debounce against a sample-window reference model.
module tb_btn_debounce;
  localparam int S    = 2;
  localparam int D    = 16;
  localparam int L    = 40;
  localparam int HIST = S + D + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       btn_0, btn_1, btn_2, btn_3;
  logic [3:0] btn_press;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  logic [3:0] btn_long;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: history of normalised samples, expected level/press, rise times.
  logic [3:0] samp_q[$];
  logic [3:0] m_q;
  logic [3:0] m_q_prev;
  logic [3:0] m_press;
  int         rise_t[4];

  btn_debounce #(
    .SYNC_STAGES      (S),
    .DEBOUNCE_CYCLES  (D),
    .BTN_ACTIVE_LOW   (1'b1),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_0    (btn_0),
    .btn_1    (btn_1),
    .btn_2    (btn_2),
    .btn_3    (btn_3),
    .btn_press(btn_press)
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    ,
    .btn_long (btn_long)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] levels();
    return {btn_3, btn_2, btn_1, btn_0};
  endfunction

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  function automatic logic [3:0] m_long();
    logic [3:0] v;
    for (int ch = 0; ch < 4; ch++) v[ch] = m_q[ch] && ((cyc - rise_t[ch]) >= L);
    return v;
  endfunction
`endif

  // A level is accepted when the D samples seen by the debouncer at this edge
  // (taken S..S+D-1 edges ago) all disagree with the current level.
  task automatic model_edge(input logic [3:0] raw, input logic r);
    logic [3:0] nq;
    bit         all_diff;
    cyc++;
    if (r) begin
      foreach (samp_q[j]) samp_q[j] = 4'h0;
      samp_q.push_back(4'h0);
      m_q      = 4'h0;
      m_q_prev = 4'h0;
      m_press  = 4'h0;
    end else begin
      samp_q.push_back(raw ^ 4'hF);
      m_press = m_q & ~m_q_prev;
      nq = m_q;
      if (samp_q.size() >= S + D) begin
        for (int ch = 0; ch < 4; ch++) begin
          all_diff = 1'b1;
          for (int j = S; j < S + D; j++)
            if (samp_q[samp_q.size() - 1 - j][ch] == m_q[ch]) all_diff = 1'b0;
          if (all_diff) begin
            nq[ch] = ~m_q[ch];
            if (!m_q[ch]) rise_t[ch] = cyc;
          end
        end
      end
      m_q_prev = m_q;
      m_q      = nq;
    end
    while (samp_q.size() > HIST) void'(samp_q.pop_front());
  endtask

  // Driver: apply inputs on the falling edge, update model on the rising edge, compare just after.
  task automatic step(input logic [3:0] raw, input logic r);
    @(negedge clk);
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    model_edge(raw, r);
    #1;
    check("level", {28'd0, levels()}, {28'd0, m_q});
    check("press", {28'd0, btn_press}, {28'd0, m_press});
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    check("long", {28'd0, btn_long}, {28'd0, m_long()});
`endif
  endtask

  initial begin
    int         lat;
    int         npulse;
    logic [3:0] seen;
    logic [3:0] lvl;
    int         hold[4];

    btn_raw = 4'hF;
    rst     = 1'b1;
    for (int ch = 0; ch < 4; ch++) rise_t[ch] = 0;

    // 1: idle after reset, all released
    for (int j = 0; j < 3; j++) step(4'hF, 1'b1);
    check("t1_reset_levels", {28'd0, levels()}, 32'd0);
    check("t1_reset_press", {28'd0, btn_press}, 32'd0);
    seen = 4'h0;
    for (int j = 0; j < 100; j++) begin
      step(4'hF, 1'b0);
      seen = seen | levels() | btn_press;
    end
    check("t1_idle", {28'd0, seen}, 32'd0);

    // 2: press button 0, measure latency and pulse
    lat = -1;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      step(4'hE, 1'b0);
      if (btn_0) lat = j;
    end
    check("t2_latency", lat, 17);
    check("t2_others", {28'd0, levels()}, 32'd1);
    step(4'hE, 1'b0);
    check("t2_press", {28'd0, btn_press}, 32'd1);
    step(4'hE, 1'b0);
    check("t2_press_one", {28'd0, btn_press}, 32'd0);

    // 3: glitchy button 1 never accepted, then accepted
    seen = 4'h0;
    for (int g = 0; g < 10; g++) begin
      for (int j = 0; j < 15; j++) begin
        step(4'hC, 1'b0);
        seen = seen | levels() | btn_press;
      end
      step(4'hE, 1'b0);
      seen = seen | levels() | btn_press;
    end
    check("t3_glitch", {31'd0, seen[1]}, 32'd0);
    for (int j = 0; j < 20; j++) step(4'hC, 1'b0);
    check("t3_accept", {31'd0, btn_1}, 32'd1);

    // 4: simultaneous press and release of all buttons
    for (int j = 0; j < 40; j++) step(4'hF, 1'b0);
    check("t4_released", {28'd0, levels()}, 32'd0);
    lat = -1;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      step(4'h0, 1'b0);
      if (levels() != 4'h0) lat = j;
    end
    check("t4_rise_lat", lat, 17);
    check("t4_same_edge", {28'd0, levels()}, 32'hF);
    step(4'h0, 1'b0);
    check("t4_press_all", {28'd0, btn_press}, 32'hF);
    lat  = -1;
    seen = 4'h0;
    for (int j = 0; j < 40; j++) begin
      step(4'hF, 1'b0);
      seen = seen | btn_press;
      if (lat < 0 && levels() == 4'h0) lat = j;
    end
    check("t4_fall_lat", lat, 17);
    check("t4_no_release_pulse", {28'd0, seen}, 32'd0);

    // 5: reset mid-count on button 2
    for (int j = 0; j < 12; j++) step(4'hB, 1'b0);
    step(4'hB, 1'b1);
    check("t5_reset", {28'd0, levels()}, 32'd0);
    lat    = -1;
    npulse = 0;
    for (int j = 0; j < 40; j++) begin
      step(4'hB, 1'b0);
      if (btn_press[2]) npulse++;
      if (lat < 0 && btn_2) lat = j;
    end
    check("t5_relatency", lat, 17);
    check("t5_one_pulse", npulse, 1);

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    // 6: long press on button 3
    lat = -1;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      step(4'h3, 1'b0);
      if (btn_3) lat = j;
    end
    check("t6_rise", lat, 17);
    lat = -1;
    for (int j = 1; j <= 60 && lat < 0; j++) begin
      step(4'h3, 1'b0);
      if (btn_long[3]) lat = j;
    end
    check("t6_long_lat", lat, L);
    lat = -1;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      step(4'hB, 1'b0);
      if (!btn_3) lat = j;
    end
    check("t6_fall", lat, 17);
    check("t6_long_drop", {31'd0, btn_long[3]}, 32'd0);
`endif

    // Random phase: per-button random hold lengths, occasional reset
    lvl = 4'hF;
    for (int ch = 0; ch < 4; ch++) hold[ch] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < 4; ch++) begin
        hold[ch]--;
        if (hold[ch] <= 0) begin
          lvl[ch]  = ~lvl[ch];
          hold[ch] = $urandom_range(1, 40);
        end
      end
      step(lvl, ($urandom_range(0, 599) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
